// File: rtl/ntt_coeff_buffer.sv
// Coefficient buffer for the NTT memory wrapper: operand bank A feeds the
// wrapper's read port, result bank B captures its writes and streams to the host.
module ntt_coeff_buffer #(
  parameter int LOGQ       = 64,
  parameter int LOGN       = 12,
  parameter int AW         = (LOGN < 9) ? 10 : LOGN,
  parameter int DELAY_BRAM = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            host_in_valid,
  output logic            host_in_ready,
  input  logic [LOGQ-1:0] host_in_0,
  input  logic [LOGQ-1:0] host_in_1,
  input  logic            host_intt,
  output logic            ntt_rst,
  output logic            ntt_start,
  output logic            ntt_intt,
  input  logic [AW-1:0]   ntt_read_address,
  output logic [LOGQ-1:0] ntt_data_in_0,
  output logic [LOGQ-1:0] ntt_data_in_1,
  input  logic [AW-1:0]   ntt_write_address,
  input  logic            ntt_wea,
  input  logic [LOGQ-1:0] ntt_data_out_0,
  input  logic [LOGQ-1:0] ntt_data_out_1,
  input  logic            ntt_finish,
  output logic            host_out_valid,
  input  logic            host_out_ready,
  output logic [LOGQ-1:0] host_out_0,
  output logic [LOGQ-1:0] host_out_1,
  output logic            busy,
  output logic            done
);

  localparam int unsigned HALF  = 1 << (LOGN - 1);
  localparam int unsigned DEPTH = DELAY_BRAM + 1;
  localparam int CW = LOGN;
  localparam int IW = (LOGN > 1) ? LOGN - 1 : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);
  localparam int WW = 2 * LOGQ;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, UNLOAD} state_t;

  state_t state_q, state_d;
  logic [CW-1:0] load_cnt_q, load_cnt_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic ntt_rst_q, ntt_rst_d, ntt_start_q, ntt_start_d;
  logic ntt_intt_q, ntt_intt_d, done_q, done_d;

  logic [WW-1:0] bank_a [HALF];
  logic [WW-1:0] bank_b [HALF];
  logic [WW-1:0] fifo_mem [DEPTH];

  logic [WW-1:0] a_pipe_q [DELAY_BRAM];
  logic [WW-1:0] a_pipe_d [DELAY_BRAM];
  logic [WW-1:0] b_pipe_q [DELAY_BRAM];
  logic [WW-1:0] b_pipe_d [DELAY_BRAM];
  logic [DELAY_BRAM-1:0] b_vld_q, b_vld_d;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] fifo_cnt_q, fifo_cnt_d;

  logic in_fire, out_fire, rd_issue, push;
  logic [IW-1:0] a_waddr;
  int unsigned occ;
  logic unused_wr_hi;

  assign unused_wr_hi   = ^ntt_write_address[AW-1:IW];
  assign host_in_ready  = (state_q == IDLE) || (state_q == LOAD);
  assign in_fire        = host_in_valid && host_in_ready;
  assign host_out_valid = (fifo_cnt_q != '0);
  assign out_fire       = host_out_valid && host_out_ready;
  assign push           = b_vld_q[DELAY_BRAM-1];
  assign a_waddr        = (state_q == IDLE) ? '0 : load_cnt_q[IW-1:0];
  assign {host_out_0, host_out_1}       = fifo_mem[rd_ptr_q];
  assign {ntt_data_in_0, ntt_data_in_1} = a_pipe_q[DELAY_BRAM-1];
  assign ntt_rst   = ntt_rst_q;
  assign ntt_start = ntt_start_q;
  assign ntt_intt  = ntt_intt_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);

  // Reads are issued only while the pipeline plus FIFO has a free slot,
  // counting a slot freed by this cycle's pop, so the FIFO never overflows.
  always_comb begin
    occ = 32'(fifo_cnt_q);
    for (int unsigned k = 0; k < DELAY_BRAM; k++) begin
      if (b_vld_q[k]) occ = occ + 1;
    end
    if (out_fire) occ = occ - 1;
    rd_issue = (state_q == UNLOAD) && (32'(rd_cnt_q) < HALF) && (occ < DEPTH);
  end

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    out_cnt_d  = out_cnt_q;
    ntt_intt_d = ntt_intt_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_fire) begin
          ntt_intt_d = host_intt;
          if (HALF == 1) begin
            state_d = RUN;
          end else begin
            load_cnt_d = CW'(1);
            state_d    = LOAD;
          end
        end
      end
      LOAD: begin
        if (in_fire) begin
          if (load_cnt_q == LAST) begin
            load_cnt_d = '0;
            state_d    = RUN;
          end else begin
            load_cnt_d = load_cnt_q + CW'(1);
          end
        end
      end
      RUN: begin
        if (ntt_finish) state_d = UNLOAD;
      end
      UNLOAD: begin
        if (rd_issue) rd_cnt_d = rd_cnt_q + CW'(1);
        if (out_fire) begin
          if (out_cnt_q == LAST) begin
            out_cnt_d = '0;
            rd_cnt_d  = '0;
            done_d    = 1'b1;
            state_d   = IDLE;
          end else begin
            out_cnt_d = out_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    ntt_rst_d   = (state_d != RUN);
    ntt_start_d = (state_d == RUN) && (state_q != RUN);
  end

  always_comb begin
    a_pipe_d[0] = ((state_q == RUN) && (32'(ntt_read_address) < HALF))
                  ? bank_a[ntt_read_address[IW-1:0]] : '0;
    b_pipe_d[0] = bank_b[rd_cnt_q[IW-1:0]];
    b_vld_d[0]  = rd_issue;
    for (int unsigned k = 1; k < DELAY_BRAM; k++) begin
      a_pipe_d[k] = a_pipe_q[k-1];
      b_pipe_d[k] = b_pipe_q[k-1];
      b_vld_d[k]  = b_vld_q[k-1];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push)     wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (out_fire) rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    fifo_cnt_d = fifo_cnt_q;
    if (push && !out_fire)      fifo_cnt_d = fifo_cnt_q + FW'(1);
    else if (!push && out_fire) fifo_cnt_d = fifo_cnt_q - FW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      load_cnt_q  <= '0;
      rd_cnt_q    <= '0;
      out_cnt_q   <= '0;
      ntt_rst_q   <= 1'b1;
      ntt_start_q <= 1'b0;
      ntt_intt_q  <= 1'b0;
      done_q      <= 1'b0;
      b_vld_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      for (int unsigned k = 0; k < DELAY_BRAM; k++) begin
        a_pipe_q[k] <= '0;
        b_pipe_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      out_cnt_q   <= out_cnt_d;
      ntt_rst_q   <= ntt_rst_d;
      ntt_start_q <= ntt_start_d;
      ntt_intt_q  <= ntt_intt_d;
      done_q      <= done_d;
      b_vld_q     <= b_vld_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      for (int unsigned k = 0; k < DELAY_BRAM; k++) begin
        a_pipe_q[k] <= a_pipe_d[k];
        b_pipe_q[k] <= b_pipe_d[k];
      end
    end
  end

  // Storage is never reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (in_fire) bank_a[a_waddr] <= {host_in_0, host_in_1};
    if ((state_q == RUN) && ntt_wea) bank_b[ntt_write_address[IW-1:0]] <= {ntt_data_out_0, ntt_data_out_1};
    if (push) fifo_mem[wr_ptr_q] <= b_pipe_q[DELAY_BRAM-1];
  end

endmodule
